// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: delimits frames by t1.5/t3.5 silence, buffers bytes,
// checks CRC-16 and slave address, and holds good frames for the command engine.
module modbus_rtu_rx_framer #(
  parameter int CLKS_PER_BIT = 347,
  parameter int MAX_FRAME    = 256
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic [7:0] i_Slave_Addr,
  input  logic       i_Frame_Ack,
  input  logic [7:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic       o_Frame_Valid,
  output logic [8:0] o_Frame_Len,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam logic [19:0] T15     = 20'((33 * CLKS_PER_BIT) / 2);
  localparam logic [19:0] T35     = 20'((77 * CLKS_PER_BIT) / 2);
  localparam int          AW      = (MAX_FRAME > 1) ? $clog2(MAX_FRAME) : 1;
  localparam logic [8:0]  MAX_CNT = 9'(MAX_FRAME);

  localparam logic [1:0] ERR_CRC      = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_GAP      = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_RECEIVE,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [15:0] crc_q, crc_d;
  logic [8:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        gap_q, gap_d;
  logic [7:0]  addr0_q, addr0_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [8:0]  len_q, len_d;
  logic [7:0]  rd_data_q;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    buf_mem [MAX_FRAME];

  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = i_Rx_DV ? 20'd0 : ((timer_q == T35) ? timer_q : timer_q + 20'd1);
    crc_d   = crc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    gap_d   = gap_q;
    addr0_d = addr0_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    len_d   = len_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[AW-1:0];

    unique case (state_q)
      S_WAIT_IDLE: begin
        if (!i_Rx_DV && timer_q == T35) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (i_Rx_DV) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          crc_d   = crc_byte(16'hFFFF, i_Rx_Byte);
          count_d = 9'd1;
          ovf_d   = 1'b0;
          gap_d   = 1'b0;
          addr0_d = i_Rx_Byte;
          state_d = S_RECEIVE;
        end
      end

      S_RECEIVE: begin
        if (i_Rx_DV) begin
          if (timer_q >= T15) begin
            gap_d = 1'b1;
          end else if (count_q == MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            crc_d   = crc_byte(crc_q, i_Rx_Byte);
            count_d = count_q + 9'd1;
          end
        end else if (timer_q == T35) begin
          // Frame check is resolved in this final silent cycle so the result
          // pulse lands exactly one cycle after the timer reaches t3.5.
          state_d = S_IDLE;
          if (count_q < 9'd4) begin
            err_d  = 1'b1;
            code_d = ERR_SHORT;
          end else if (ovf_q) begin
            err_d  = 1'b1;
            code_d = ERR_OVERFLOW;
          end else if (gap_q) begin
            err_d  = 1'b1;
            code_d = ERR_GAP;
          end else if (crc_q != 16'h0000) begin
            err_d  = 1'b1;
            code_d = ERR_CRC;
          end else if (addr0_q == i_Slave_Addr || addr0_q == 8'h00) begin
            valid_d = 1'b1;
            len_d   = count_q - 9'd2;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Leave through WAIT_IDLE so a frame already in flight is never half-captured.
        if (i_Frame_Ack) state_d = S_WAIT_IDLE;
      end

      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_WAIT_IDLE;
      timer_q <= '0;
      crc_q   <= 16'hFFFF;
      count_q <= '0;
      ovf_q   <= 1'b0;
      gap_q   <= 1'b0;
      addr0_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      gap_q   <= gap_d;
      addr0_q <= addr0_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) buf_mem[wr_idx] <= i_Rx_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_data_q <= '0;
    end else if ({1'b0, i_Rd_Addr} < MAX_CNT) begin
      rd_data_q <= buf_mem[i_Rd_Addr[AW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign o_Rd_Data     = rd_data_q;
  assign o_Frame_Valid = valid_q;
  assign o_Frame_Len   = len_q;
  assign o_Frame_Err   = err_q;
  assign o_Err_Code    = code_q;
  assign o_Busy        = (state_q == S_HOLD);

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Directed bench for modbus_rtu_rx_framer: table of frames plus hand-written
// HOLD, overflow and reset sequences; a second instance uses MAX_FRAME=8.
module tb_modbus_rtu_rx_framer;

  localparam int LAT = 155;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = '0;
  logic [7:0] slave_addr = 8'h01;
  logic       frame_ack = 1'b0;
  logic [7:0] rd_addr = '0;

  logic [7:0] rd_data, rd_data8;
  logic       f_valid, f_valid8, f_err, f_err8, busy, busy8;
  logic [8:0] f_len, f_len8;
  logic [1:0] e_code, e_code8;

  always #5 clk = ~clk;

  modbus_rtu_rx_framer #(.CLKS_PER_BIT(4), .MAX_FRAME(256)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_Slave_Addr(slave_addr), .i_Frame_Ack(frame_ack), .i_Rd_Addr(rd_addr),
    .o_Rd_Data(rd_data), .o_Frame_Valid(f_valid), .o_Frame_Len(f_len),
    .o_Frame_Err(f_err), .o_Err_Code(e_code), .o_Busy(busy)
  );

  modbus_rtu_rx_framer #(.CLKS_PER_BIT(4), .MAX_FRAME(8)) dut8 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_Slave_Addr(slave_addr), .i_Frame_Ack(frame_ack), .i_Rd_Addr(rd_addr),
    .o_Rd_Data(rd_data8), .o_Frame_Valid(f_valid8), .o_Frame_Len(f_len8),
    .o_Frame_Err(f_err8), .o_Err_Code(e_code8), .o_Busy(busy8)
  );

  typedef struct {
    logic [127:0] data;
    int           n;
    bit           add_crc;
    bit           flip;
    int           gap_idx;
    bit           exp_valid;
    bit           exp_err;
    logic [1:0]   exp_code;
    logic [8:0]   exp_len;
  } vec_t;

  vec_t vecs [8];
  int total = 0;
  int bad = 0;

  int         obs_nv, obs_ne, obs_k, obs8_ne, obs8_k;
  logic [1:0] obs_code, obs8_code;
  logic [8:0] obs_len;
  logic       obs_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bench_crc(input logic [127:0] data, input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = data[(n-1-i)*8 +: 8];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic send_frame(input logic [127:0] data, input int n, input int gap_idx);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (((i == gap_idx) ? 80 : 40) - 1) @(negedge clk);
      rx_byte = data[(n-1-i)*8 +: 8];
      rx_dv   = 1'b1;
      @(negedge clk);
      rx_dv   = 1'b0;
    end
  endtask

  // Sample k reflects DUT state after the k-th edge following the last strobe.
  task automatic observe(input int win);
    obs_nv = 0; obs_ne = 0; obs_k = -1; obs8_ne = 0; obs8_k = -1;
    obs_code = '0; obs8_code = '0; obs_len = '0; obs_busy = 1'b0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if ((f_valid || f_err) && obs_k < 0) begin
        obs_k = k; obs_code = e_code; obs_len = f_len; obs_busy = busy;
      end
      if (f_err8 && obs8_k < 0) begin
        obs8_k = k; obs8_code = e_code8;
      end
      if (f_valid) obs_nv++;
      if (f_err) obs_ne++;
      if (f_err8) obs8_ne++;
    end
  endtask

  task automatic ack_and_idle();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check("busy_after_ack", busy, 0);
    repeat (200) @(negedge clk);
  endtask

  localparam logic [127:0] GOOD = 128'h0103_0000_000A_C5CD;

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{GOOD, 8, 0, 0, -1, 1, 0, 2'd0, 9'd6};
    vecs[1] = '{128'h0103_0000_000A_C5CE, 8, 0, 0, -1, 0, 1, 2'd0, 9'd0};
    vecs[2] = '{GOOD, 8, 0, 0, 4, 0, 1, 2'd3, 9'd0};
    vecs[3] = '{128'h01_0300, 3, 0, 0, -1, 0, 1, 2'd1, 9'd0};
    vecs[4] = '{128'h0203_0000_000A, 6, 1, 0, -1, 0, 0, 2'd0, 9'd0};
    vecs[5] = '{128'h0003_0000_000A, 6, 1, 0, -1, 1, 0, 2'd0, 9'd6};
    vecs[6] = '{128'h0107, 2, 1, 0, -1, 1, 0, 2'd0, 9'd2};
    vecs[7] = '{128'h0107, 2, 1, 1, -1, 0, 1, 2'd0, 9'd0};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].add_crc) begin
        logic [15:0] c;
        c = bench_crc(vecs[i].data, vecs[i].n);
        vecs[i].data = (vecs[i].data << 16) | {112'd0, c[7:0], c[15:8]};
        vecs[i].n = vecs[i].n + 2;
      end
      if (vecs[i].flip) vecs[i].data[0] = ~vecs[i].data[0];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", f_valid, 0);
    check("rst_err", f_err, 0);
    check("rst_busy", busy, 0);
    check("rst_len", f_len, 0);
    check("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].n, vecs[v].gap_idx);
      observe(300);
      $display("frame %0d: valid=%0d err=%0d code=%0d len=%0d lat=%0d",
               v, obs_nv, obs_ne, obs_code, obs_len, obs_k);
      check($sformatf("v%0d_valid_cnt", v), obs_nv, vecs[v].exp_valid);
      check($sformatf("v%0d_err_cnt", v), obs_ne, vecs[v].exp_err);
      if (vecs[v].exp_valid || vecs[v].exp_err)
        check($sformatf("v%0d_latency", v), obs_k, LAT);
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d_code", v), obs_code, vecs[v].exp_code);
        check($sformatf("v%0d_busy_err", v), obs_busy, 0);
      end
      if (vecs[v].exp_valid) begin
        check($sformatf("v%0d_len", v), obs_len, vecs[v].exp_len);
        check($sformatf("v%0d_busy_valid", v), obs_busy, 1);
        for (int i = 0; i < int'(vecs[v].exp_len); i++) begin
          rd_addr = 8'(i);
          @(negedge clk);
          check($sformatf("v%0d_rd%0d", v, i), rd_data, vecs[v].data[(vecs[v].n-1-i)*8 +: 8]);
        end
        ack_and_idle();
      end else begin
        check($sformatf("v%0d_busy_idle", v), busy, 0);
        repeat (200) @(negedge clk);
      end
    end

    // Overflow on the MAX_FRAME=8 instance; the deep instance sees a CRC error
    send_frame({GOOD, 16'h1122}, 10, -1);
    observe(300);
    $display("overflow: err8=%0d code8=%0d lat8=%0d err=%0d code=%0d",
             obs8_ne, obs8_code, obs8_k, obs_ne, obs_code);
    check("ovf_err_cnt", obs8_ne, 1);
    check("ovf_code", obs8_code, 2);
    check("ovf_latency", obs8_k, LAT);
    check("ovf_deep_code", obs_code, 0);
    repeat (200) @(negedge clk);

    // Frame streamed during HOLD, ack mid-stream
    send_frame(GOOD, 8, -1);
    observe(160);
    check("hold_valid", obs_nv, 1);
    check("hold_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      rx_byte = 8'h5A + 8'(i);
      rx_dv = 1'b1;
      @(negedge clk);
      rx_dv = 1'b0;
      if (i == 1) begin
        rd_addr = 8'd0;
        @(negedge clk);
        check("hold_frozen", rd_data, 8'h01);
        repeat (38) @(negedge clk);
      end else if (i == 2) begin
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("hold_ack_busy", busy, 0);
        repeat (38) @(negedge clk);
      end else if (i < 7) begin
        repeat (39) @(negedge clk);
      end
    end
    observe(300);
    $display("hold stream: valid=%0d err=%0d", obs_nv, obs_ne);
    check("stream_valid", obs_nv, 0);
    check("stream_err", obs_ne, 0);
    send_frame(GOOD, 8, -1);
    observe(300);
    $display("after hold: valid=%0d lat=%0d", obs_nv, obs_k);
    check("after_hold_valid", obs_nv, 1);
    check("after_hold_latency", obs_k, LAT);
    ack_and_idle();

    // Reset mid-frame
    rd_addr = 8'd0;
    send_frame(128'h0103_0000, 4, -1);
    @(negedge clk);
    check("pre_rst_rd", rd_data, 8'h01);
    rst_n = 1'b0;
    #1;
    $display("mid-frame reset: rd=%0h len=%0d busy=%0d code8=%0d", rd_data, f_len, busy, e_code8);
    check("mrst_rd", rd_data, 0);
    check("mrst_len", f_len, 0);
    check("mrst_busy", busy, 0);
    check("mrst_code8", e_code8, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(GOOD, 8, -1);
    observe(300);
    $display("post-reset early frame: valid=%0d err=%0d", obs_nv, obs_ne);
    check("early_valid", obs_nv, 0);
    check("early_err", obs_ne, 0);
    send_frame(GOOD, 8, -1);
    observe(300);
    $display("post-reset frame: valid=%0d len=%0d lat=%0d", obs_nv, obs_len, obs_k);
    check("late_valid", obs_nv, 1);
    check("late_len", obs_len, 6);
    check("late_latency", obs_k, LAT);
    ack_and_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
